branch_predict_unit: RTL

Parametrised successor to the combinational branch comparator. It pairs a branch-history table (BHT) of 2-bit saturating counters, read combinationally at fetch, with a registered execute-stage resolver. The resolver evaluates BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR, computes targets and link address, detects mispredictions, trains the BHT and keeps saturating statistics. It sits between the fetch PC mux (prediction, redirect) and the execute stage (operands, decoded control).

---
 rtl/branch_predict_unit_if.sv | 41 ++++
 rtl/branch_predict_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch lookup and execute resolve bundle for branch_predict_unit
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  f_pc;
  logic             f_pred_taken;
  logic             ex_valid;
  logic             flush;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  rs1data;
  logic [XLEN-1:0]  rs2data;
  logic [2:0]       func3;
  logic             binst;
  logic             jal;
  logic             jalr;
  logic             ex_pred_taken;
  logic             res_valid;
  logic             pcjump;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic [XLEN-1:0]  link_pc;
  logic             illegal;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output f_pc, ex_valid, flush, ex_pc, ex_imm, rs1data, rs2data, func3,
           binst, jal, jalr, ex_pred_taken,
    input  f_pred_taken, res_valid, pcjump, redirect, redirect_pc, link_pc,
           illegal, br_cnt, mispred_cnt
  );

  modport slave (
    input  f_pc, ex_valid, flush, ex_pc, ex_imm, rs1data, rs2data, func3,
           binst, jal, jalr, ex_pred_taken,
    output f_pred_taken, res_valid, pcjump, redirect, redirect_pc, link_pc,
           illegal, br_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - 2-bit BHT predictor with registered execute-stage branch resolver
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  branch_predict_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] ex_idx;

  logic             res_valid_q, res_valid_d;
  logic             pcjump_q, pcjump_d;
  logic             redirect_q, redirect_d;
  logic             illegal_q, illegal_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0]  link_pc_q, link_pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic             bht_we;
  logic [1:0]       bht_d;

  logic             accept;
  logic             is_jal, is_jalr, is_br;
  logic             br_illegal, br_legal;
  logic             cond;
  logic [XLEN-1:0]  link_addr, br_target, jalr_target;
  logic             unused_bits;

  // Only the index slice of the fetch PC matters for lookup.
  assign unused_bits = ^bus.f_pc;

  assign f_idx  = bus.f_pc[IDX_LSB +: IDX_W];
  assign ex_idx = bus.ex_pc[IDX_LSB +: IDX_W];
  assign bus.f_pred_taken = bht_q[f_idx][1];

  assign accept      = bus.ex_valid & ~bus.flush;
  assign is_jal      = bus.jal;
  assign is_jalr     = ~bus.jal & bus.jalr;
  assign is_br       = ~bus.jal & ~bus.jalr & bus.binst;
  assign br_illegal  = is_br & (bus.func3[2:1] == 2'b01);
  assign br_legal    = is_br & ~br_illegal;

  assign link_addr   = bus.ex_pc + XLEN'(4);
  assign br_target   = bus.ex_pc + bus.ex_imm;
  assign jalr_target = (bus.rs1data + bus.ex_imm) & ~XLEN'(1);

  always_comb begin
    cond = 1'b0;
    case (bus.func3)
      3'b000:  cond = (bus.rs1data == bus.rs2data);
      3'b001:  cond = (bus.rs1data != bus.rs2data);
      3'b100:  cond = ($signed(bus.rs1data) <  $signed(bus.rs2data));
      3'b101:  cond = ($signed(bus.rs1data) >= $signed(bus.rs2data));
      3'b110:  cond = (bus.rs1data <  bus.rs2data);
      3'b111:  cond = (bus.rs1data >= bus.rs2data);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    res_valid_d   = 1'b0;
    pcjump_d      = 1'b0;
    redirect_d    = 1'b0;
    illegal_d     = 1'b0;
    redirect_pc_d = redirect_pc_q;
    link_pc_d     = link_pc_q;
    if (accept) begin
      res_valid_d   = 1'b1;
      link_pc_d     = link_addr;
      redirect_pc_d = link_addr;
      if (is_jal) begin
        pcjump_d      = 1'b1;
        redirect_d    = 1'b1;
        redirect_pc_d = br_target;
      end else if (is_jalr) begin
        pcjump_d      = 1'b1;
        redirect_d    = 1'b1;
        redirect_pc_d = jalr_target;
      end else if (br_illegal) begin
        illegal_d     = 1'b1;
        redirect_d    = bus.ex_pred_taken;
      end else if (br_legal) begin
        pcjump_d      = cond;
        redirect_d    = cond ^ bus.ex_pred_taken;
        redirect_pc_d = cond ? br_target : link_addr;
      end
    end
  end

  // Training and statistics only see legal branches that were actually accepted.
  always_comb begin
    bht_we        = accept & br_legal;
    bht_d         = bht_q[ex_idx];
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bht_we) begin
      if (cond && bht_q[ex_idx] != 2'b11) begin
        bht_d = bht_q[ex_idx] + 2'b01;
      end else if (!cond && bht_q[ex_idx] != 2'b00) begin
        bht_d = bht_q[ex_idx] - 2'b01;
      end
      if (br_cnt_q != '1) begin
        br_cnt_d = br_cnt_q + CNT_W'(1);
      end
      if (redirect_d && mispred_cnt_q != '1) begin
        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
      res_valid_q   <= 1'b0;
      pcjump_q      <= 1'b0;
      redirect_q    <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_pc_q <= '0;
      link_pc_q     <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (bht_we) begin
        bht_q[ex_idx] <= bht_d;
      end
      res_valid_q   <= res_valid_d;
      pcjump_q      <= pcjump_d;
      redirect_q    <= redirect_d;
      illegal_q     <= illegal_d;
      redirect_pc_q <= redirect_pc_d;
      link_pc_q     <= link_pc_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.res_valid   = res_valid_q;
  assign bus.pcjump      = pcjump_q;
  assign bus.redirect    = redirect_q;
  assign bus.illegal     = illegal_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.link_pc     = link_pc_q;
  assign bus.br_cnt      = br_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
endmodule
